accel_tile_sched: RTL and testbench

Batch scheduler that runs an HLS kernel with `ap_ctrl_hs` control (ap_start/ap_ready/ap_done) over a sequence of tiles held in host memory. Per tile it requests a buffer load from the host-side loader, starts the kernel, waits for completion, then requests a buffer store. It sits between the host control registers and the existing loader/storer plus kernel pair, and replaces the single-shot sequencing in the current top level. It also keeps per-phase cycle counters for profiling and flags kernel hangs.

---
 rtl/accel_tile_sched_if.sv | 16 +
 rtl/accel_tile_sched.sv | 119 +++++++++++
 tb/tb_accel_tile_sched.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/accel_tile_sched_if.sv
// accel_tile_sched_if: loader, storer and ap_ctrl_hs kernel handshakes seen by the tile scheduler
interface accel_tile_sched_if;
  logic        ld_req;
  logic [63:0] ld_addr;
  logic        ld_done;
  logic        st_req;
  logic [63:0] st_addr;
  logic        st_done;
  logic        ap_start;
  logic        ap_ready;
  logic        ap_done;
  modport master(output ld_req, ld_addr, st_req, st_addr, ap_start,
                 input ld_done, st_done, ap_ready, ap_done);
  modport slave(input ld_req, ld_addr, st_req, st_addr, ap_start,
                output ld_done, st_done, ap_ready, ap_done);
endinterface

// File: rtl/accel_tile_sched.sv
// accel_tile_sched: per-tile load / kernel run / store sequencer with phase profiling and hang detection
module accel_tile_sched #(
  parameter int TILE_WID = 16,
  parameter int TIMEOUT  = 1000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [63:0]         read_base,
  input  logic [63:0]         write_base,
  input  logic [63:0]         tile_stride,
  input  logic [TILE_WID-1:0] num_tiles,
  accel_tile_sched_if.master  bus,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [TILE_WID-1:0] tile_idx,
  output logic [63:0]         cyc_load,
  output logic [63:0]         cyc_kern,
  output logic [63:0]         cyc_store
);
  localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, KSTART = 3'd2, KRUN = 3'd3,
                         STORE = 3'd4, NEXT = 3'd5, FIN = 3'd6;
  localparam int HW = (TIMEOUT > 1) ? $clog2(TIMEOUT) + 1 : 1;
  logic [2:0]          state_q, state_d;
  logic [63:0]         rb_q, rb_d, wb_q, wb_d, stride_q, stride_d, off_q, off_d;
  logic [TILE_WID-1:0] nt_q, nt_d, tile_idx_q, tile_idx_d;
  logic [HW-1:0]       hang_q, hang_d;
  logic [63:0]         cyc_load_q, cyc_load_d, cyc_kern_q, cyc_kern_d, cyc_store_q, cyc_store_d;
  logic [63:0]         ld_addr_q, st_addr_q;
  logic                busy_q, busy_d, done_q, err_q, err_d, ld_req_q, st_req_q, ap_start_q;
  logic                go, adv, in_k, hang_hit, timed_out;
  assign go       = state_q == IDLE && start;
  assign in_k     = state_q == KSTART || state_q == KRUN;
  assign hang_hit = (TIMEOUT != 0) && (hang_q == HW'(TIMEOUT - 1));
  // ap_done wins over a timeout landing in the same cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = !start ? IDLE : (num_tiles == '0) ? FIN : LOAD;
      LOAD:    state_d = bus.ld_done ? KSTART : LOAD;
      KSTART:  state_d = (bus.ap_ready && bus.ap_done) ? STORE : hang_hit ? FIN : bus.ap_ready ? KRUN : KSTART;
      KRUN:    state_d = bus.ap_done ? STORE : hang_hit ? FIN : KRUN;
      STORE:   state_d = bus.st_done ? NEXT : STORE;
      NEXT:    state_d = (tile_idx_q + TILE_WID'(1) == nt_q) ? FIN : LOAD;
      default: state_d = IDLE;
    endcase
  end
  assign adv         = state_q == NEXT && state_d == LOAD;
  assign timed_out   = in_k && state_d == FIN;
  assign rb_d        = go ? read_base : rb_q;
  assign wb_d        = go ? write_base : wb_q;
  assign stride_d    = go ? tile_stride : stride_q;
  assign nt_d        = go ? num_tiles : nt_q;
  // running offset equals tile_idx * tile_stride without a multiplier
  assign off_d       = go ? '0 : adv ? off_q + stride_q : off_q;
  assign tile_idx_d  = go ? '0 : adv ? tile_idx_q + TILE_WID'(1) : tile_idx_q;
  assign err_d       = go ? 1'b0 : timed_out ? 1'b1 : err_q;
  assign busy_d      = state_q != IDLE || start;
  assign hang_d      = in_k ? hang_q + HW'(1) : '0;
  assign cyc_load_d  = go ? '0 : cyc_load_q + 64'(state_q == LOAD);
  assign cyc_kern_d  = go ? '0 : cyc_kern_q + 64'(in_k);
  assign cyc_store_d = go ? '0 : cyc_store_q + 64'(state_q == STORE);
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rb_q        <= '0;
      wb_q        <= '0;
      stride_q    <= '0;
      nt_q        <= '0;
      off_q       <= '0;
      tile_idx_q  <= '0;
      hang_q      <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cyc_load_q  <= '0;
      cyc_kern_q  <= '0;
      cyc_store_q <= '0;
      ld_req_q    <= 1'b0;
      st_req_q    <= 1'b0;
      ap_start_q  <= 1'b0;
      ld_addr_q   <= '0;
      st_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      rb_q        <= rb_d;
      wb_q        <= wb_d;
      stride_q    <= stride_d;
      nt_q        <= nt_d;
      off_q       <= off_d;
      tile_idx_q  <= tile_idx_d;
      hang_q      <= hang_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      done_q      <= state_q == FIN;
      cyc_load_q  <= cyc_load_d;
      cyc_kern_q  <= cyc_kern_d;
      cyc_store_q <= cyc_store_d;
      ld_req_q    <= state_d == LOAD;
      st_req_q    <= state_d == STORE;
      ap_start_q  <= state_d == KSTART;
      ld_addr_q   <= rb_d + off_d;
      st_addr_q   <= wb_d + off_d;
    end
  end
  assign bus.ld_req   = ld_req_q;
  assign bus.ld_addr  = ld_addr_q;
  assign bus.st_req   = st_req_q;
  assign bus.st_addr  = st_addr_q;
  assign bus.ap_start = ap_start_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign tile_idx     = tile_idx_q;
  assign cyc_load     = cyc_load_q;
  assign cyc_kern     = cyc_kern_q;
  assign cyc_store    = cyc_store_q;
endmodule

// File: tb/tb_accel_tile_sched.sv
// tb_accel_tile_sched: randomized batches with latency-configurable loader/storer/kernel models
module tb_accel_tile_sched;
  localparam int TMO = 50;
  logic        clk = 1'b0;
  logic        reset, start;
  logic [63:0] read_base, write_base, tile_stride;
  logic [15:0] num_tiles, tile_idx;
  logic        busy, done, err;
  logic [63:0] cyc_load, cyc_kern, cyc_store;
  int          n_chk = 0, n_bad = 0;
  int          ld_lat = 1, st_lat = 1, rdy_lat = 1, run_lat = 1;
  bit          spur = 1'b0;
  int          lc, sc, kc, rc, kph;
  accel_tile_sched_if bus();
  accel_tile_sched #(.TILE_WID(16), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .read_base(read_base), .write_base(write_base),
    .tile_stride(tile_stride), .num_tiles(num_tiles), .bus(bus), .busy(busy), .done(done),
    .err(err), .tile_idx(tile_idx), .cyc_load(cyc_load), .cyc_kern(cyc_kern), .cyc_store(cyc_store));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // loader/storer answer after a fixed latency; kernel gives ap_ready then ap_done
  always @(posedge clk) begin
    #1;
    if (reset || !busy) begin
      lc = 0; sc = 0; kph = 0;
    end
    bus.ap_ready = 1'b0;
    bus.ap_done  = 1'b0;
    if (bus.ld_req) begin
      lc++;
      bus.ld_done = lc == ld_lat;
    end else begin
      lc = 0;
      bus.ld_done = spur && $urandom_range(0, 3) == 0;
    end
    if (bus.st_req) begin
      sc++;
      bus.st_done = sc == st_lat;
    end else begin
      sc = 0;
      bus.st_done = spur && $urandom_range(0, 3) == 0;
    end
    if (kph == 0 && bus.ap_start) begin
      kph = 1; kc = 0;
    end
    if (kph == 1) begin
      kc++;
      if (kc == rdy_lat) begin
        bus.ap_ready = 1'b1;
        kph = 2; rc = 0;
        if (run_lat == 0) begin
          bus.ap_done = 1'b1;
          kph = 0;
        end
      end
    end else if (kph == 2) begin
      rc++;
      if (rc == run_lat) begin
        bus.ap_done = 1'b1;
        kph = 0;
      end
    end else if (spur && !bus.ap_start) begin
      bus.ap_ready = $urandom_range(0, 3) == 0;
      bus.ap_done  = $urandom_range(0, 3) == 0;
    end
  end
  task automatic run_batch(input logic [63:0] rb, input logic [63:0] wb, input logic [63:0] sd,
                           input logic [15:0] n, input int ll, input int sl, input int rl,
                           input int kl, input bit sp);
    int kern = rl + kl;
    bit to = n != 0 && kern > TMO;
    int loads = (n == 0) ? 0 : to ? 1 : int'(n);
    int stores = to ? 0 : int'(n);
    int d = to ? 2 + ll + TMO : 2 + int'(n) * (ll + kern + sl + 1);
    int cyc = 1, nl = 0, ns = 0, aps = 0, bsy = 0, ovl = 0, ndone = 0, err_at = -1, done_at = -1;
    logic pl = 1'b0, ps = 1'b0;
    logic [63:0] la = '0, sa = '0;
    ld_lat = ll; st_lat = sl; rdy_lat = rl; run_lat = kl; spur = sp;
    read_base = rb; write_base = wb; tile_stride = sd; num_tiles = n; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_t1", 64'(busy), 64'(1));
    check("ld_req_t1", 64'(bus.ld_req), 64'(n != 0));
    check("err_cleared", 64'(err), 64'(0));
    while (cyc < 3000 && (done_at < 0 || cyc <= done_at + 3)) begin
      if (bus.ld_req && !pl) begin
        la = rb + 64'(nl) * sd;
        check("ld_addr", bus.ld_addr, la);
        nl++;
      end else if (bus.ld_req) check("ld_hold", bus.ld_addr, la);
      if (bus.st_req && !ps) begin
        sa = wb + 64'(ns) * sd;
        check("st_addr", bus.st_addr, sa);
        ns++;
      end else if (bus.st_req) check("st_hold", bus.st_addr, sa);
      if (bus.ap_start) aps++;
      if (busy) bsy++;
      if (32'(bus.ld_req) + 32'(bus.st_req) + 32'(bus.ap_start) > 1) ovl++;
      if (err && err_at < 0) err_at = cyc;
      if (done) begin
        ndone++;
        if (done_at < 0) done_at = cyc;
      end
      start = sp && busy && !done && $urandom_range(0, 5) == 0;
      if (start) begin
        read_base = {$urandom, $urandom}; write_base = {$urandom, $urandom};
        tile_stride = {$urandom, $urandom}; num_tiles = 16'($urandom_range(0, 9));
      end
      pl = bus.ld_req; ps = bus.st_req;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    if (done_at < 0) check("done_seen", 64'(0), 64'(1));
    check("done_cycle", 64'(done_at), 64'(d));
    check("done_pulses", 64'(ndone), 64'(1));
    check("busy_cycles", 64'(bsy), 64'(d));
    check("busy_after", 64'(busy), 64'(0));
    check("loads", 64'(nl), 64'(loads));
    check("stores", 64'(ns), 64'(stores));
    check("ap_start_cycles", 64'(aps), 64'(loads * rl));
    check("overlap", 64'(ovl), 64'(0));
    check("err", 64'(err), 64'(to));
    check("err_rise", 64'(err_at), 64'(to ? d - 1 : -1));
    check("cyc_load", cyc_load, 64'(loads * ll));
    check("cyc_kern", cyc_kern, 64'(loads * (to ? TMO : kern)));
    check("cyc_store", cyc_store, 64'(stores * sl));
    check("tile_idx", 64'(tile_idx), 64'((n == 0 || to) ? 0 : int'(n) - 1));
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
    check({tag, "_err"}, 64'(err), 64'(0));
    check({tag, "_idx"}, 64'(tile_idx), 64'(0));
    check({tag, "_reqs"}, 64'({bus.ld_req, bus.st_req, bus.ap_start}), 64'(0));
    check({tag, "_addrs"}, bus.ld_addr | bus.st_addr, 64'(0));
    check({tag, "_cycs"}, cyc_load | cyc_kern | cyc_store, 64'(0));
  endtask
  task automatic reset_in_krun();
    int w = 0, nd = 0, nr = 0;
    bit seen = 1'b0;
    ld_lat = 3; st_lat = 3; rdy_lat = 1; run_lat = 40; spur = 1'b0;
    read_base = 64'h2000; write_base = 64'h9000; tile_stride = 64'h100; num_tiles = 16'd3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (!(seen && !bus.ap_start) && w < 200) begin
      if (bus.ap_start) seen = 1'b1;
      @(posedge clk); #1;
      w++;
    end
    if (w >= 200) check("krun_reached", 64'(0), 64'(1));
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_zero("mid_reset");
    repeat (80) begin
      @(posedge clk); #1;
      if (done) nd++;
      if (bus.ld_req || bus.st_req || bus.ap_start) nr++;
    end
    check("post_reset_done", 64'(nd), 64'(0));
    check("post_reset_reqs", 64'(nr), 64'(0));
  endtask
  initial begin
    reset = 1'b1; start = 1'b0;
    read_base = '0; write_base = '0; tile_stride = '0; num_tiles = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    reset = 1'b0;
    @(posedge clk); #1;
    run_batch(64'h1000, 64'h8000, 64'h400, 16'd3, 5, 7, 1, 19, 1'b0);
    check("basic_cyc_load", cyc_load, 64'd15);
    check("basic_cyc_store", cyc_store, 64'd21);
    run_batch(64'h1000, 64'h8000, 64'h400, 16'd0, 2, 2, 1, 1, 1'b0);
    run_batch(64'h40, 64'h80, 64'h10, 16'd2, 2, 3, 4, 6, 1'b0);
    run_batch(64'h40, 64'h80, 64'h10, 16'd2, 2, 3, 2, 0, 1'b0);
    run_batch(64'h5000, 64'h6000, 64'h20, 16'd2, 3, 3, 1, 1000, 1'b0);
    run_batch(64'h5000, 64'h6000, 64'h20, 16'd1, 3, 3, 1, 3, 1'b0);
    run_batch(64'h100, 64'h200, 64'h8, 16'd3, 3, 2, 2, 4, 1'b1);
    reset_in_krun();
    run_batch(64'h3000, 64'h7000, 64'h40, 16'd2, 2, 2, 1, 5, 1'b0);
    run_batch({32'hFFFFFFFF, 32'hFFFFF000}, 64'h0, {32'h8000_0000, 32'h0}, 16'd3, 1, 1, 1, 0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      run_batch({$urandom, $urandom}, {$urandom, $urandom},
                ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, 4096)) : {$urandom, $urandom},
                16'($urandom_range(0, 4)), $urandom_range(1, 6), $urandom_range(1, 6),
                $urandom_range(1, 5),
                ($urandom_range(0, 7) == 0) ? 60 : $urandom_range(0, 10),
                1'($urandom_range(0, 1)));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end
endmodule
